// File: rtl/aes_key_expand_seq.sv
// Iterative AES-256 key schedule generator: expands one 32-bit word per cycle and
// presents the 60-word (15 round key) chain on a valid/yumi handshake.
module aes_key_expand_seq (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [255:0]  key_i,
  input  logic          v_i,
  output logic          ready_o,
  output logic [1919:0] key_chain_o,
  output logic          v_o,
  input  logic          yumi_i
);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  localparam logic [5:0] LAST_WORD = 6'd59;

  // FIPS-197 forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic [5:0]  r_cnt;
  logic [7:0]  r_rcon;
  logic [31:0] r_w [60];

  logic [31:0] w_prev;
  logic [31:0] w_back8;
  logic [31:0] w_sub_in;
  logic [31:0] w_sub_out;
  logic [31:0] w_temp;
  logic [31:0] w_new;
  logic        w_is_rot;
  logic        w_is_sub;
  logic        w_accept;

  assign w_accept = v_i && (r_state == S_IDLE);
  assign w_is_rot = (r_cnt[2:0] == 3'd0);
  assign w_is_sub = (r_cnt[2:0] == 3'd4);
  assign w_prev   = r_w[r_cnt - 6'd1];
  assign w_back8  = r_w[r_cnt - 6'd8];

  // One shared 4-byte SubWord; RotWord is applied in front of it only on rcon words.
  assign w_sub_in  = w_is_rot ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign w_sub_out = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                      sbox(w_sub_in[15:8]),  sbox(w_sub_in[7:0])};

  always_comb begin
    w_temp = w_prev;
    if (w_is_rot)      w_temp = w_sub_out ^ {r_rcon, 24'h0};
    else if (w_is_sub) w_temp = w_sub_out;
  end

  assign w_new = w_back8 ^ w_temp;

  // NOTE: every word register is reset because key_chain_o must read zero after reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_rcon  <= 8'h01;
      for (int i = 0; i < 60; i++) r_w[i] <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            for (int i = 0; i < 8; i++) r_w[i] <= key_i[255 - 32*i -: 32];
            r_cnt  <= 6'd8;
            r_rcon <= 8'h01;
          end
        end
        S_EXPAND: begin
          r_w[r_cnt] <= w_new;
          if (w_is_rot) r_rcon <= {r_rcon[6:0], 1'b0};
          if (r_cnt != LAST_WORD) r_cnt <= r_cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    ready_o      = 1'b0;
    v_o          = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (v_i) w_state_next = S_EXPAND;
      end
      S_EXPAND: begin
        if (r_cnt == LAST_WORD) w_state_next = S_DONE;
      end
      S_DONE: begin
        v_o = 1'b1;
        if (yumi_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  for (genvar g = 0; g < 60; g++) begin : g_chain
    assign key_chain_o[1919 - 32*g -: 32] = r_w[g];
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq: FIPS-197 vectors, handshake corners and
// random keys against a GF(2^8)-derived key schedule and inverse cipher model.
module tb_aes_key_expand_seq;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [255:0]  key_i;
  logic          v_i;
  logic          ready_o;
  logic [1919:0] key_chain_o;
  logic          v_o;
  logic          yumi_i;

  always #5 clk_i = ~clk_i;

  aes_key_expand_seq dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .key_i       (key_i),
    .v_i         (v_i),
    .ready_o     (ready_o),
    .key_chain_o (key_chain_o),
    .v_o         (v_o),
    .yumi_i      (yumi_i)
  );

  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] r;
    logic [7:0] s;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(b));
      if (b == 0) inv = 8'h00;
      r = inv;
      s = inv;
      repeat (4) begin
        r = {r[6:0], r[7]};
        s ^= r;
      end
      sb[b] = s ^ 8'h63;
    end
    for (int b = 0; b < 256; b++) isb[sb[b]] = 8'(b);
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [1919:0] ref_expand(input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] chain;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int i = 0; i < 60; i++) chain[1919 - 32*i -: 32] = w[i];
    return chain;
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [1919:0] chain, input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] k;
    logic [127:0] pt;
    logic [7:0]   a0, a1, a2, a3;
    k = chain[127:0];
    for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
    for (int r = 13; r >= 0; r--) begin
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++)
          t[row + 4*c] = isb[s[row + 4*((c - row + 4) % 4)]];
      k = chain[1919 - 128*r -: 128];
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ k[127 - 8*i -: 8];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
          s[4*c+1] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
          s[4*c+2] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
          s[4*c+3] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
        end
      end
    end
    for (int i = 0; i < 16; i++) pt[127 - 8*i -: 8] = s[i];
    return pt;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_chain(input string tag, input logic [1919:0] exp);
    for (int r = 0; r < 15; r++)
      check($sformatf("%s_rk%0d", tag, r), key_chain_o[1919 - 128*r -: 128],
            exp[1919 - 128*r -: 128]);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  // Drives the key for one edge; returns just after the accept edge.
  task automatic accept_key(input string tag, input logic [255:0] key);
    check({tag, "_ready_before"}, 128'(ready_o), 128'(1'b1));
    key_i = key;
    v_i   = 1'b1;
    tick();
    v_i   = 1'b0;
    check({tag, "_ready_after"}, 128'(ready_o), 128'(1'b0));
  endtask

  // Counts edges from the accept edge until v_o; optionally noisy inputs meanwhile.
  task automatic wait_done(input string tag, input bit noisy);
    int cycles;
    cycles = 0;
    do begin
      if (noisy) begin
        v_i    = 1'($urandom);
        yumi_i = 1'($urandom);
        key_i  = rand_key();
      end
      tick();
      cycles++;
    end while (!v_o && cycles < 100);
    v_i    = 1'b0;
    yumi_i = 1'b0;
    check({tag, "_latency"}, 128'(cycles), 128'(52));
    check({tag, "_ready_done"}, 128'(ready_o), 128'(1'b0));
  endtask

  task automatic release_chain(input string tag);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    check({tag, "_idle_ready"}, 128'(ready_o), 128'(1'b1));
    check({tag, "_idle_v"}, 128'(v_o), 128'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [1919:0] exp_c3;
    logic [1919:0] exp_a3;
    logic [1919:0] exp_rnd;
    logic [255:0]  k;

    reset_i = 1'b1;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    key_i   = '0;
    build_sbox();
    exp_c3 = ref_expand(KEY_C3);
    exp_a3 = ref_expand(KEY_A3);

    // Reset
    tick();
    tick();
    reset_i = 1'b0;
    check("rst_ready", 128'(ready_o), 128'(1'b1));
    check("rst_v", 128'(v_o), 128'(1'b0));
    check_chain("rst", '0);
    tick();
    check("rst_idle_hold", 128'(ready_o), 128'(1'b1));

    // FIPS-197 C.3 key
    accept_key("c3", KEY_C3);
    wait_done("c3", 1'b0);
    check("c3_rk0",  key_chain_o[1919 -: 128], 128'h000102030405060708090a0b0c0d0e0f);
    check("c3_rk1",  key_chain_o[1791 -: 128], 128'h101112131415161718191a1b1c1d1e1f);
    check("c3_rk2",  key_chain_o[1663 -: 128], 128'ha573c29fa176c498a97fce93a572c09c);
    check("c3_rk14", key_chain_o[127:0],       128'h24fc79ccbf0979e9371ac23c6d68de36);
    check_chain("c3_model", exp_c3);
    check("c3_decrypt", ref_decrypt(key_chain_o, 128'h8ea2b7ca516745bfeafc49904b496089),
          128'h00112233445566778899aabbccddeeff);

    // Backpressure in DONE with v_i and key_i moving
    for (int i = 0; i < 10; i++) begin
      v_i   = ~v_i;
      key_i = rand_key();
      tick();
      check($sformatf("bp%0d_v", i), 128'(v_o), 128'(1'b1));
      check($sformatf("bp%0d_ready", i), 128'(ready_o), 128'(1'b0));
      check_chain($sformatf("bp%0d", i), exp_c3);
    end
    v_i = 1'b0;
    release_chain("bp");

    // Reset in the middle of EXPAND (reset sampled at E20)
    accept_key("mid", rand_key());
    repeat (19) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("mid_rst_ready", 128'(ready_o), 128'(1'b1));
    check("mid_rst_v", 128'(v_o), 128'(1'b0));
    check_chain("mid_rst", '0);
    accept_key("mid_c3", KEY_C3);
    wait_done("mid_c3", 1'b0);
    check_chain("mid_c3", exp_c3);

    // Back-to-back: yumi, then A.3 key on the very next cycle
    release_chain("b2b");
    accept_key("a3", KEY_A3);
    wait_done("a3", 1'b0);
    check("a3_w8",  128'(key_chain_o[1919 - 32*8 -: 32]), 128'(32'h9ba35411));
    check("a3_w59", 128'(key_chain_o[31:0]),              128'(32'h706c631e));
    check_chain("a3", exp_a3);

    // Random keys, with v_i/yumi_i/key_i noise during EXPAND that must be ignored
    for (int n = 0; n < 4; n++) begin
      release_chain($sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 3)) tick();
      k       = rand_key();
      exp_rnd = ref_expand(k);
      accept_key($sformatf("rnd%0d", n), k);
      wait_done($sformatf("rnd%0d", n), 1'b1);
      check_chain($sformatf("rnd%0d", n), exp_rnd);
    end
    release_chain("end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes_key_expand_seq.md
# aes_key_expand_seq

Iterative AES-256 key schedule generator that sits directly upstream of the AES-256 encryption and decryption datapaths. It accepts one 256-bit cipher key over a valid/ready handshake and computes the full 60-word round-key schedule one 32-bit word per cycle. It then presents the 15 round keys as a single 1920-bit `key_chain` bus under a valid/yumi handshake, so the combinational cipher stages never need their own key expansion.

## Interface
- No parameters. AES-256 only: Nk=8, Nr=14, 60 words.
- `clk_i` input 1 — single clock; all state updates on the rising edge.
- `reset_i` input 1 — synchronous, active-high reset.
- `key_i` input 256 — cipher key, FIPS-197 byte order (`key_i[255:248]` is key byte 0); sampled only on an accept.
- `v_i` input 1 — `key_i` valid.
- `ready_o` output 1 — block can accept a key.
- `key_chain_o` output 1920 — round keys 0..14. Word w[i] sits at bits [1919-32*i -: 32], so round key 0 is [1919:1792] (= `key_i[255:128]`) and round key 14 is [127:0].
- `v_o` output 1 — `key_chain_o` is complete and valid.
- `yumi_i` input 1 — consumer takes the chain; legal only while `v_o`=1.

## Operation
- States: IDLE, EXPAND, DONE.
- **IDLE**
  - `ready_o`=1, `v_o`=0.
  - Accept is `v_i & ready_o`. On accept, words w0..w7 load from `key_i`, word counter loads 8, rcon loads 0x01, next state is EXPAND.
- **EXPAND**
  - `ready_o`=0, `v_o`=0. Each cycle writes w[cnt] = w[cnt-8] ^ temp, where w[cnt-1] is the most recently written word.
  - If cnt%8==0: temp = SubWord(RotWord(w[cnt-1])) ^ {rcon,24'h0}; rcon then shifts left by 1. Rcon sequence is 01,02,04,08,10,20,40.
  - If cnt%8==4: temp = SubWord(w[cnt-1]).
  - Otherwise: temp = w[cnt-1].
  - RotWord: {b1,b2,b3,b0}. SubWord applies the FIPS-197 forward S-box to each byte, using the same table as the encryption datapath. One 4-byte SubWord instance is shared across all cycles.
  - When cnt==59 is written, the next state is DONE. The counter is 6 bits and never exceeds 59.
- **DONE**
  - `v_o`=1, `ready_o`=0. `key_chain_o` is held stable.
  - On `yumi_i`, next state is IDLE.
  - `v_i` is ignored in DONE and EXPAND. A new key cannot be accepted in the same cycle as `yumi_i`.
- `key_chain_o` is a register and changes only on reset, on accept (words 0..7), or on an EXPAND write. Words not yet written keep their prior contents; consumers must wait for `v_o`.
- `yumi_i` is ignored outside DONE.

## Timing
- Reset values: state=IDLE, `ready_o`=1, `v_o`=0, `key_chain_o`=0, counter=0, rcon=0x01.
- `reset_i` asserted in any state, including mid-EXPAND and DONE, returns to the reset values at the next edge. A partial schedule is discarded.
- Latency: accept at edge E0. Words w8..w59 are written at edges E1..E52. `v_o` rises after E52, i.e. 52 cycles from the accept edge to `v_o` high.
- Throughput: minimum 54 cycles per key (accept, 52 EXPAND cycles, at least 1 DONE cycle with `yumi_i`, return to IDLE).
- Earliest next accept is the cycle after the `yumi_i` edge.
- No combinational path from `v_i` or `yumi_i` to any output; `ready_o` and `v_o` are decoded from state only.

## Test plan
- **Reset:** hold `reset_i` for 2 cycles, then release → `ready_o`=1, `v_o`=0, `key_chain_o`=0.
- **FIPS-197 C.3 key:** `key_i`=000102…1e1f, pulse `v_i` → `v_o` high exactly 52 cycles after accept, with:
  - round key 0 = 000102030405060708090a0b0c0d0e0f
  - round key 1 = 101112131415161718191a1b1c1d1e1f
  - round key 2 = a573c29fa176c498a97fce93a572c09c
  - round key 14 = 24fc79ccbf0979e9371ac23c6d68de36
  - the same chain fed to the decryption datapath with ciphertext 8ea2b7ca516745bfeafc49904b496089 recovers 00112233445566778899aabbccddeeff.
- **FIPS-197 A.3 key:** `key_i`=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → w8=9ba35411, w59=706c631e.
- **Backpressure:** hold `yumi_i`=0 for 10 cycles in DONE while toggling `v_i` and `key_i` → `key_chain_o` unchanged, `v_o`=1, `ready_o`=0. Pulse `yumi_i` → IDLE the next cycle.
- **Reset mid-EXPAND:** assert `reset_i` at E20 → outputs return to reset values. The C.3 key accepted afterwards produces the correct chain in 52 cycles.
- **Back-to-back:** `yumi_i`, then `v_i` with the A.3 key on the following cycle → accepted immediately, correct A.3 chain, no stale C.3 words in round keys 2..14.
